hangman_game_ctrl: RTL



---
 rtl/hangman_pkg.sv | 30 +++
 rtl/hangman_game_ctrl_sec_tick_gen.sv | 29 ++
 rtl/hangman_game_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game controller.
package hangman_pkg;

  typedef logic [4:0] letter_t;

  localparam int      NUM_LETTERS = 26;
  localparam letter_t LETTER_NONE = 5'h1F;

  typedef enum logic [2:0] {
    S_PLAY,
    S_HELD,
    S_EVAL,
    S_WON,
    S_LOST
  } game_state_t;

  // Outcome of one guess evaluation, listed in priority order.
  typedef enum logic [1:0] {
    R_INVALID,
    R_REPEAT,
    R_HIT,
    R_MISS
  } eval_res_t;

  // Only A..Z (0..25) are real letters.
  function automatic logic letter_valid(input letter_t l);
    return l < letter_t'(NUM_LETTERS);
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_sec_tick_gen.sv
// One-second tick prescaler: a down-counter that pulses tick for one cycle
// at terminal count and reloads. Counting pauses while en is low.
module sec_tick_gen #(
  parameter int unsigned CYCLES_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CYCLES_PER_SEC - 1);

  logic [CW-1:0] cnt_q;

  // Down-count while enabled; reload at terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RELOAD;
    end else if (en) begin
      if (cnt_q == '0) cnt_q <= RELOAD;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: one guess evaluation per go press/release, owns
// the revealed mask, guessed-letter set, wrong count and win/loss result.
// Optional countdown timer is built only when HANGMAN_TIMER_EN is defined.
//
// state  | meaning
// S_PLAY | idle, waiting for go
// S_HELD | go is down, waiting for release (guess latched on release)
// S_EVAL | one-cycle classification of the latched guess
// S_WON  | every letter revealed; terminal until reset
// S_LOST | out of wrong guesses or time; terminal until reset
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN       = 4,
  parameter int unsigned MAX_WRONG      = 8,
  parameter int unsigned CYCLES_PER_SEC = 50_000_000,
  parameter int unsigned TIME_LIMIT     = 60
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [4:0]              guess,
  input  logic [5*WORD_LEN-1:0]   word,
  output logic [WORD_LEN-1:0]     letter_mask,
  output logic [NUM_LETTERS-1:0]  guessed_set,
  output logic [3:0]              wrong_count,
  output logic [3:0]              guesses_left,
  output logic [7:0]              time_left,
  output logic                    hit,
  output logic                    miss,
  output logic                    repeat_guess,
  output logic                    invalid_guess,
  output logic                    game_won,
  output logic                    game_lost
);

  localparam logic [3:0] MAX_WRONG_C = MAX_WRONG[3:0];

  game_state_t            state_q, state_d;
  letter_t                guess_q;
  logic [WORD_LEN-1:0]    match;
  logic [WORD_LEN-1:0]    mask_next;
  logic [NUM_LETTERS-1:0] letter_oh;
  logic [3:0]             wrong_next;
  eval_res_t              res;
  logic                   timeout;

`ifdef HANGMAN_TIMER_EN
  logic       tick;
  logic       tick_en;
  logic [7:0] time_left_q;

  assign tick_en = (state_q == S_PLAY) || (state_q == S_HELD) || (state_q == S_EVAL);

  sec_tick_gen #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_sec_tick (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .tick (tick)
  );

  // Countdown in seconds; stops at zero and freezes once the game ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_left_q <= TIME_LIMIT[7:0];
    end else if (tick && (time_left_q != 8'd0)) begin
      time_left_q <= time_left_q - 8'd1;
    end
  end

  assign time_left = time_left_q;
  assign timeout   = (time_left_q == 8'd0);
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = CYCLES_PER_SEC ^ TIME_LIMIT;
  assign time_left  = 8'd0;
  assign timeout    = 1'b0;
`endif

  // Classify the latched guess and compute the post-evaluation values.
  always_comb begin
    letter_oh  = 26'd1 << guess_q;
    match      = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      match[i] = (word[5*i +: 5] == guess_q);
    end

    if (!letter_valid(guess_q))            res = R_INVALID;
    else if (|(guessed_set & letter_oh))   res = R_REPEAT;
    else if (|match)                       res = R_HIT;
    else                                   res = R_MISS;

    mask_next  = letter_mask;
    wrong_next = wrong_count;
    if (res == R_HIT) begin
      mask_next = letter_mask | match;
    end
    if ((res == R_MISS) && (wrong_count != MAX_WRONG_C)) begin
      wrong_next = wrong_count + 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_PLAY;
    else       state_q <= state_d;
  end

  // Next-state logic; evaluation outcome outranks a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PLAY: begin
        if (timeout)  state_d = S_LOST;
        else if (go)  state_d = S_HELD;
      end
      S_HELD: begin
        if (timeout)  state_d = S_LOST;
        else if (!go) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (&mask_next)                    state_d = S_WON;
        else if (wrong_next == MAX_WRONG_C) state_d = S_LOST;
        else if (timeout)                  state_d = S_LOST;
        else                               state_d = S_PLAY;
      end
      S_WON:   state_d = S_WON;
      S_LOST:  state_d = S_LOST;
      default: state_d = S_PLAY;
    endcase
  end

  // Guess latch, game state updates and one-cycle result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      guess_q       <= LETTER_NONE;
      letter_mask   <= '0;
      guessed_set   <= '0;
      wrong_count   <= 4'd0;
      hit           <= 1'b0;
      miss          <= 1'b0;
      repeat_guess  <= 1'b0;
      invalid_guess <= 1'b0;
    end else begin
      hit           <= 1'b0;
      miss          <= 1'b0;
      repeat_guess  <= 1'b0;
      invalid_guess <= 1'b0;
      if ((state_q == S_HELD) && (state_d == S_EVAL)) begin
        guess_q <= guess;
      end
      if (state_q == S_EVAL) begin
        letter_mask <= mask_next;
        wrong_count <= wrong_next;
        case (res)
          R_INVALID: invalid_guess <= 1'b1;
          R_REPEAT:  repeat_guess  <= 1'b1;
          R_HIT: begin
            hit         <= 1'b1;
            guessed_set <= guessed_set | letter_oh;
          end
          default: begin
            miss        <= 1'b1;
            guessed_set <= guessed_set | letter_oh;
          end
        endcase
      end
    end
  end

  assign guesses_left = MAX_WRONG_C - wrong_count;
  assign game_won     = (state_q == S_WON);
  assign game_lost    = (state_q == S_LOST);

endmodule
